// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared state encoding and width helper for scan_mux
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_mux_ctr.sv
// rtl/scan_mux_ctr.sv - dwell/channel counter pair for auto-scan
module scan_mux_ctr
  import scan_mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DWELL = 4,
  localparam int SELW = sel_width(NCH),
  localparam int DWW  = sel_width(DWELL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  output logic [SELW-1:0] o_ch,
  output logic            o_wrap
);

  logic [SELW-1:0] r_ch;
  logic [DWW-1:0]  r_dw;
  logic            r_wrap_pend;
  logic            w_last_dw;
  logic            w_last_ch;

  assign w_last_dw = (int'(r_dw) == DWELL - 1);
  assign w_last_ch = (int'(r_ch) == NCH - 1);

  // r_ch/r_dw describe the sample taken on the next scan edge; i_run=0 clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_dw        <= '0;
      r_wrap_pend <= 1'b0;
    end else if (!i_run) begin
      r_ch        <= '0;
      r_dw        <= '0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_wrap_pend <= w_last_dw && w_last_ch;
      if (w_last_dw) begin
        r_dw <= '0;
        r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
      end else begin
        r_dw <= r_dw + 1'b1;
      end
    end
  end

  assign o_ch   = r_ch;
  assign o_wrap = r_wrap_pend;

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered channel multiplexer with direct select and dwell-based auto-scan
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SELW = sel_width(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH*W-1:0]  in,
  output logic [W-1:0]      out,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  output logic              sel_err,
  output logic              wrap
);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_out;
  logic [SELW-1:0] r_out_ch;
  logic            r_out_valid;
  logic            r_sel_err;
  logic            r_wrap;
  logic [SELW-1:0] w_ch;
  logic            w_wrap_pend;
  logic [SELW-1:0] w_idx;
  logic [W-1:0]    w_pick;
  logic            w_sel_ok;

  always_comb begin
    w_next = ST_IDLE;
    if (en) w_next = mode ? ST_SCAN : ST_DIRECT;
  end

  scan_mux_ctr #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (w_next == ST_SCAN),
    .o_ch   (w_ch),
    .o_wrap (w_wrap_pend)
  );

  assign w_idx    = (w_next == ST_SCAN) ? w_ch : sel;
  assign w_sel_ok = (int'(sel) < NCH);

  // Out-of-range indices match no channel and yield zero.
  always_comb begin
    w_pick = '0;
    for (int k = 0; k < NCH; k++)
      if (w_idx == SELW'(k)) w_pick = in[k*W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (w_next)
        ST_DIRECT: begin
          r_out       <= w_sel_ok ? w_pick : '0;
          r_out_ch    <= w_sel_ok ? sel : '0;
          r_out_valid <= w_sel_ok;
          r_sel_err   <= !w_sel_ok;
          r_wrap      <= 1'b0;
        end
        ST_SCAN: begin
          r_out       <= w_pick;
          r_out_ch    <= w_ch;
          r_out_valid <= 1'b1;
          r_sel_err   <= 1'b0;
          // A pending wrap only survives if the previous edge was also a scan edge.
          r_wrap      <= w_wrap_pend && (r_state == ST_SCAN);
        end
        default: begin
          r_out_valid <= 1'b0;
          r_sel_err   <= 1'b0;
          r_wrap      <= 1'b0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed self-checking bench for scan_mux
module tb_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [2:0]  sel8;
  logic [7:0]  in8;
  logic [0:0]  out8;
  logic [2:0]  ch8;
  logic        val8;
  logic        err8;
  logic        wrap8;
  logic [2:0]  sel6;
  logic [23:0] in6;
  logic [3:0]  out6;
  logic [2:0]  ch6;
  logic        val6;
  logic        err6;
  logic        wrap6;

  int checks = 0;
  int errors = 0;

  scan_mux #(.NCH(8), .W(1), .DWELL(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel8), .in(in8),
    .out(out8), .out_ch(ch8), .out_valid(val8), .sel_err(err8), .wrap(wrap8)
  );

  scan_mux #(.NCH(6), .W(4), .DWELL(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel6), .in(in6),
    .out(out6), .out_ch(ch6), .out_valid(val6), .sel_err(err6), .wrap(wrap6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int ch, input int o, input int v, input int wr);
    chk({tag, ".ch8"},   64'(ch8),   64'(ch));
    chk({tag, ".out8"},  64'(out8),  64'(o));
    chk({tag, ".val8"},  64'(val8),  64'(v));
    chk({tag, ".wrap8"}, 64'(wrap8), 64'(wr));
  endtask

  task automatic chk_zero(input string tag);
    chk8(tag, 0, 0, 0, 0);
    chk({tag, ".err8"}, 64'(err8), 64'd0);
    chk({tag, ".out6"}, 64'(out6), 64'd0);
    chk({tag, ".ch6"},  64'(ch6),  64'd0);
    chk({tag, ".val6"}, 64'(val6), 64'd0);
    chk({tag, ".err6"}, 64'(err6), 64'd0);
    chk({tag, ".wrap6"}, 64'(wrap6), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    sel8  = 3'd0;
    sel6  = 3'd0;
    in8   = 8'h55;
    in6   = 24'hFEDCBA;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    step();
    step();
    chk_zero("reset_held");
    rst_n = 1'b1;

    // Direct select: in8=0x55 -> ch0=1, ch1=0, ch2=1; in6 ch k = 0xA+k.
    en = 1'b1; mode = 1'b0; sel8 = 3'd0; sel6 = 3'd5;
    step();
    chk8("dir_sel0", 0, 1, 1, 0);
    chk("dir_sel0.err8", 64'(err8), 64'd0);
    chk("dir6_sel5.out", 64'(out6), 64'hF);
    chk("dir6_sel5.ch",  64'(ch6),  64'd5);
    chk("dir6_sel5.val", 64'(val6), 64'd1);
    sel8 = 3'd1; sel6 = 3'd7;
    step();
    chk8("dir_sel1", 1, 0, 1, 0);
    chk("dir6_sel7.err", 64'(err6), 64'd1);
    chk("dir6_sel7.val", 64'(val6), 64'd0);
    chk("dir6_sel7.out", 64'(out6), 64'd0);
    chk("dir6_sel7.ch",  64'(ch6),  64'd0);
    sel8 = 3'd2; sel6 = 3'd3;
    step();
    chk8("dir_sel2", 2, 1, 1, 0);
    chk("dir6_sel3.err", 64'(err6), 64'd0);
    chk("dir6_sel3.out", 64'(out6), 64'hD);
    chk("dir6_sel3.ch",  64'(ch6),  64'd3);
    chk("dir6_sel3.val", 64'(val6), 64'd1);

    // Full scan: dut8 dwells 4 per channel, wraps on edge 32; dut6 advances every edge.
    mode = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      step();
      chk8($sformatf("scan%0d", i), (i / 4) % 8, ((i / 4) % 2 == 0) ? 1 : 0, 1, (i == 32) ? 1 : 0);
      chk($sformatf("scan6_%0d.ch", i),   64'(ch6),   64'(i % 6));
      chk($sformatf("scan6_%0d.out", i),  64'(out6),  64'(10 + i % 6));
      chk($sformatf("scan6_%0d.wrap", i), 64'(wrap6), 64'((i > 0 && i % 6 == 0) ? 1 : 0));
    end

    // Live sampling within a dwell: ch0 of 0xAA is 0.
    in8 = 8'hAA;
    step();
    chk8("live_aa", 0, 0, 1, 0);
    in8 = 8'h55;
    step();
    chk8("live_55", 0, 1, 1, 0);
    chk("live6.out", 64'(out6), 64'hE);

    // Disabled: hold last data/channel, valid low.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk8($sformatf("idle%0d", i), 0, 1, 0, 0);
      chk($sformatf("idle6_%0d.out", i), 64'(out6), 64'hE);
      chk($sformatf("idle6_%0d.ch", i),  64'(ch6),  64'd4);
      chk($sformatf("idle6_%0d.val", i), 64'(val6), 64'd0);
    end

    // Re-enable restarts at ch0; run to ch3/dw2.
    en = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      step();
      chk8($sformatf("rescan%0d", i), i / 4, ((i / 4) % 2 == 0) ? 1 : 0, 1, 0);
    end

    // Two direct cycles mid-scan, sel changes with no gap.
    mode = 1'b0; sel8 = 3'd6;
    step();
    chk8("mid_dir6", 6, 1, 1, 0);
    sel8 = 3'd7;
    step();
    chk8("mid_dir7", 7, 0, 1, 0);
    mode = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      step();
      chk8($sformatf("back%0d", i), i / 4, ((i / 4) % 2 == 0) ? 1 : 0, 1, 0);
    end

    // Asynchronous reset mid-scan at ch5.
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    step();
    chk_zero("rst_mid_held");
    rst_n = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      step();
      chk8($sformatf("post_rst%0d", i), i / 4, ((i / 4) % 2 == 0) ? 1 : 0, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
